accel_spi_reader: RTL and testbench

SPI master that configures an ADXL362 accelerometer and periodically burst-reads its 8-bit X/Y/Z acceleration registers. It packs each completed sample into a 32-bit word that drives the board's 8-digit hex seven-segment display, which shows the sample counter and the X, Y and Z bytes. Sits between the accelerometer pins and the display driver, in the same clock domain.

---
 rtl/accel_spi_reader.sv | 140 ++++++++++++++
 tb/tb_accel_spi_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/accel_spi_reader.sv
// SPI mode-0 master for an ADXL362: writes POWER_CTL once, then periodically burst-reads
// XDATA/YDATA/ZDATA and packs {sample count, X, Y, Z} for an 8-digit hex display.
module accel_spi_reader #(
    parameter int CLK_DIV     = 50,
    parameter int POLL_CYCLES = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic [7:0]  x_data,
    output logic [7:0]  y_data,
    output logic [7:0]  z_data,
    output logic        sample_valid,
    output logic [31:0] display_word
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TMR_W = $clog2(POLL_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] POLL_LAST = TMR_W'(POLL_CYCLES - 1);
    localparam logic [39:0] WRITE_FRAME = {24'h0A2D02, 16'h0000};
    localparam logic [39:0] READ_FRAME  = 40'h0B08000000;

    typedef enum logic [2:0] {INIT, XFER_W, GAP, XFER_R, UPDATE} state_t;

    state_t           state, next_state;
    logic [DIV_W-1:0] div_cnt;
    logic [6:0]       half_cnt;
    logic [38:0]      tx_shift;
    logic [23:0]      rx_shift;
    logic [TMR_W-1:0] poll_timer;
    logic [7:0]       sample_cnt;
    logic [39:0]      load_frame;
    logic             in_xfer, half_end, last_half, frame_done, timer_done;
    logic             load_w, load_r;

    // A frame is 2N+1 half-periods: a lead-in low half, N high/low bit periods,
    // then a trailing low half before cs_n releases.
    assign in_xfer    = (state == XFER_W) || (state == XFER_R);
    assign half_end   = (div_cnt == DIV_LAST);
    assign last_half  = (state == XFER_R) ? (half_cnt == 7'd80) : (half_cnt == 7'd48);
    assign frame_done = in_xfer && half_end && last_half;
    assign timer_done = (poll_timer == POLL_LAST);
    assign load_frame = load_w ? WRITE_FRAME : READ_FRAME;

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= next_state;
    end

    always_comb begin
        next_state   = state;
        sample_valid = 1'b0;
        load_w       = 1'b0;
        load_r       = 1'b0;
        case (state)
            INIT: begin
                load_w     = 1'b1;
                next_state = XFER_W;
            end
            XFER_W: if (frame_done) next_state = GAP;
            GAP: if (timer_done) begin
                load_r     = 1'b1;
                next_state = XFER_R;
            end
            XFER_R: if (frame_done) next_state = UPDATE;
            UPDATE: begin
                sample_valid = 1'b1;
                next_state   = GAP;
            end
            default: next_state = INIT;
        endcase
    end

    // Bit engine: the first bit is presented together with cs_n falling,
    // miso is captured on each rise, the next mosi bit is driven on each fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
        end else if (load_w || load_r) begin
            cs_n     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= load_frame[39];
            tx_shift <= load_frame[38:0];
            div_cnt  <= '0;
            half_cnt <= '0;
        end else if (in_xfer) begin
            if (half_end) begin
                div_cnt  <= '0;
                half_cnt <= half_cnt + 7'd1;
                if (last_half) begin
                    cs_n <= 1'b1;
                    mosi <= 1'b0;
                end else if (!half_cnt[0]) begin
                    sclk     <= 1'b1;
                    rx_shift <= {rx_shift[22:0], miso};
                end else begin
                    sclk     <= 1'b0;
                    mosi     <= tx_shift[38];
                    tx_shift <= {tx_shift[37:0], 1'b0};
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Restarting the timer at the end of the init write gives the first read a full poll interval.
    always_ff @(posedge clk) begin
        if (rst)                                      poll_timer <= '0;
        else if ((state == XFER_W && frame_done) || timer_done) poll_timer <= '0;
        else                                          poll_timer <= poll_timer + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_data       <= '0;
            y_data       <= '0;
            z_data       <= '0;
            sample_cnt   <= '0;
            display_word <= '0;
        end else if (state == UPDATE) begin
            x_data       <= rx_shift[23:16];
            y_data       <= rx_shift[15:8];
            z_data       <= rx_shift[7:0];
            sample_cnt   <= sample_cnt + 8'd1;
            display_word <= {sample_cnt + 8'd1, rx_shift};
        end
    end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Scoreboard bench for accel_spi_reader: an ADXL362-like sensor model drives miso, a frame
// monitor decodes the SPI bus and a sample monitor checks each latched sample against a queue.
module tb_accel_spi_reader;

    localparam int CLK_DIV = 2;
    localparam int POLL    = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miso = 1'b0;
    logic        sclk, mosi, cs_n, sample_valid;
    logic [7:0]  x_data, y_data, z_data;
    logic [31:0] display_word;

    typedef struct {int bits; logic [39:0] data;} frame_t;
    typedef struct {logic [7:0] x; logic [7:0] y; logic [7:0] z; logic [7:0] cnt;} sample_t;

    frame_t  exp_frames[$];
    sample_t exp_samples[$];

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int idle_bad = 0;

    logic [7:0]  mx = 8'h00, my = 8'h00, mz = 8'h00;
    logic [39:0] sens_sh = '0;

    accel_spi_reader #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL)) dut (
        .clk(clk), .rst(rst), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .x_data(x_data), .y_data(y_data), .z_data(z_data),
        .sample_valid(sample_valid), .display_word(display_word)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Sensor model: 16 random don't-care bits then X, Y, Z; miso only moves on cs_n fall or SCLK fall.
    always @(negedge cs_n) begin
        sens_sh = {16'($urandom), mx, my, mz};
        miso    = sens_sh[39];
    end
    always @(negedge sclk) begin
        if (!cs_n) begin
            sens_sh = {sens_sh[38:0], 1'b0};
            miso    = sens_sh[39];
        end
    end

    // Frame monitor: decodes mosi on SCLK rises and checks every half-period length.
    logic       prev_sclk = 1'b0, prev_cs = 1'b1, in_frame = 1'b0;
    int         bit_cnt = 0, phase_len = 0;
    logic [39:0] frm_data = '0;
    frame_t     ef;

    always @(negedge clk) begin
        phase_len++;
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (prev_cs && !cs_n) begin
                in_frame  = 1'b1;
                bit_cnt   = 0;
                frm_data  = '0;
                phase_len = 0;
            end
            if (in_frame && sclk != prev_sclk) begin
                check_output(sclk ? "sclk_low_time" : "sclk_high_time", phase_len, CLK_DIV);
                phase_len = 0;
                if (sclk) begin
                    bit_cnt++;
                    frm_data = {frm_data[38:0], mosi};
                end
            end
            if (!prev_cs && cs_n && in_frame) begin
                in_frame = 1'b0;
                check_output("sclk_to_cs_time", phase_len, CLK_DIV);
                check_output("sclk_idle_at_cs_rise", sclk, 1'b0);
                if (exp_frames.size() == 0) begin
                    check_output("unexpected_frame", 1, 0);
                end else begin
                    ef = exp_frames.pop_front();
                    check_output("frame_pulses", bit_cnt, ef.bits);
                    check_output("frame_mosi", frm_data, ef.data);
                end
            end
            if (cs_n && (sclk || mosi)) idle_bad++;
        end
        prev_sclk = sclk;
        prev_cs   = cs_n;
    end

    // Sample monitor: pops the expected sample on each sample_valid and checks outputs one cycle later.
    int      last_valid = -1;
    sample_t es;

    always @(negedge clk) begin
        if (rst) begin
            last_valid = -1;
        end else if (sample_valid) begin
            if (last_valid >= 0) check_output("valid_interval", cycle - last_valid, POLL);
            last_valid = cycle;
            if (exp_samples.size() == 0) begin
                check_output("unexpected_sample", 1, 0);
            end else begin
                es = exp_samples.pop_front();
                @(negedge clk);
                check_output("valid_pulse_width", sample_valid, 1'b0);
                check_output("x_data", x_data, es.x);
                check_output("y_data", y_data, es.y);
                check_output("z_data", z_data, es.z);
                check_output("display_word", display_word, {es.cnt, es.x, es.y, es.z});
            end
        end
    end

    task automatic push_write_frame();
        exp_frames.push_back('{bits: 24, data: 40'h0A2D02});
    endtask

    task automatic apply_stimulus(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                                  input logic [7:0] cnt);
        mx = x;
        my = y;
        mz = z;
        exp_frames.push_back('{bits: 40, data: 40'h0B08000000});
        exp_samples.push_back('{x: x, y: y, z: z, cnt: cnt});
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < 3 * POLL);
        if (!sample_valid) check_output({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int   n;
        logic p;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_cs_n", cs_n, 1'b1);
        check_output("reset_sclk", sclk, 1'b0);
        check_output("reset_mosi", mosi, 1'b0);
        check_output("reset_display", display_word, 32'h0);
        check_output("reset_valid", sample_valid, 1'b0);
        check_output("reset_xyz", {x_data, y_data, z_data}, 24'h0);

        push_write_frame();
        apply_stimulus(8'h12, 8'h34, 8'h56, 8'h01);
        rst = 1'b0;
        wait_valid("sample1");
        apply_stimulus(8'hFF, 8'h80, 8'h00, 8'h02);
        wait_valid("sample2");
        for (int i = 3; i <= 257; i++) begin
            apply_stimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'(i));
            wait_valid("sample_loop");
        end

        // Abort the next read frame during its 20th bit.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cs_n && n < 2 * POLL);
        check_output("read_start_seen", cs_n, 1'b0);
        n = 0;
        p = sclk;
        while (n < 20 && !cs_n) begin
            @(negedge clk);
            if (sclk && !p) n++;
            p = sclk;
        end
        check_output("rises_before_reset", n, 20);
        rst = 1'b1;
        @(negedge clk);
        check_output("midreset_cs_n", cs_n, 1'b1);
        check_output("midreset_sclk", sclk, 1'b0);
        check_output("midreset_display", display_word, 32'h0);
        check_output("midreset_valid", sample_valid, 1'b0);
        push_write_frame();
        apply_stimulus(8'hAB, 8'hCD, 8'hEF, 8'h01);
        rst = 1'b0;
        wait_valid("sample_after_reset");
        repeat (5) @(negedge clk);

        check_output("frames_pending", exp_frames.size(), 0);
        check_output("samples_pending", exp_samples.size(), 0);
        check_output("idle_bus_activity", idle_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
